// File: rtl/gshare_btb_pred.sv
// gshare_btb_pred: gshare direction predictor (2-bit counters indexed by
// pc XOR global history) plus a fully-associative, round-robin-replaced BTB.
// Lookup results are registered; updates come from the resolve stage.
// Optional feature macro: GSHARE_BYPASS_EN -- forwards a same-cycle update
// into the lookup (counter on index match, target on PC match).
module gshare_btb_pred #(
  parameter int PCSIZE      = 16,
  parameter int BHT_IDX     = 8,
  parameter int GHR_LEN     = 8,
  parameter int BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [PCSIZE-1:0] lookup_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [PCSIZE-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [PCSIZE-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [PCSIZE-1:0] upd_target
);
  localparam int BHT_N = 1 << BHT_IDX;
  localparam int PTR_W = $clog2(BTB_ENTRIES);

  logic [1:0]             cnt     [BHT_N];
  logic [GHR_LEN-1:0]     ghr;
  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [PCSIZE-1:0]      btb_tag [BTB_ENTRIES];
  logic [PCSIZE-1:0]      btb_tgt [BTB_ENTRIES];
  logic [PTR_W-1:0]       ptr;

  // Lookup and update hash with the same (pre-update) history.
  logic [BHT_IDX-1:0] ghr_ext, lk_idx, up_idx;
  assign ghr_ext = BHT_IDX'(ghr);
  assign lk_idx  = lookup_pc[BHT_IDX+1:2] ^ ghr_ext;
  assign up_idx  = upd_pc[BHT_IDX+1:2] ^ ghr_ext;

  logic [1:0] up_cnt, up_cnt_nxt;
  assign up_cnt = cnt[up_idx];

  // Saturating next value of the counter touched by the update.
  always_comb begin
    up_cnt_nxt = up_cnt;
    if (upd_taken) begin
      if (up_cnt != 2'd3) up_cnt_nxt = up_cnt + 2'd1;
    end else begin
      if (up_cnt != 2'd0) up_cnt_nxt = up_cnt - 2'd1;
    end
  end

  // CAM search for both ports. Allocation happens only on a miss, so at most
  // one way matches and OR-ing the targets yields the hit target (0 on miss).
  logic              lk_hit, up_hit;
  logic [PCSIZE-1:0] lk_tgt;
  logic [PTR_W-1:0]  up_way;
  always_comb begin
    lk_hit = 1'b0;
    lk_tgt = '0;
    up_hit = 1'b0;
    up_way = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (btb_vld[i] && (btb_tag[i] == lookup_pc)) begin
        lk_hit = 1'b1;
        lk_tgt = lk_tgt | btb_tgt[i];
      end
      if (btb_vld[i] && (btb_tag[i] == upd_pc)) begin
        up_hit = 1'b1;
        up_way = PTR_W'(i);
      end
    end
  end

  // Final lookup view; optionally sees the update landing this cycle.
  logic [1:0]        lk_cnt;
  logic              lk_hit_f;
  logic [PCSIZE-1:0] lk_tgt_f;
  always_comb begin
    lk_cnt   = cnt[lk_idx];
    lk_hit_f = lk_hit;
    lk_tgt_f = lk_tgt;
`ifdef GSHARE_BYPASS_EN
    if (upd_valid && (up_idx == lk_idx)) lk_cnt = up_cnt_nxt;
    if (upd_valid && upd_taken && (upd_pc == lookup_pc)) begin
      lk_hit_f = 1'b1;
      lk_tgt_f = upd_target;
    end
`endif
  end

  // Registered prediction; payload holds when no lookup is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken  <= lk_hit_f && lk_cnt[1];
        pred_hit    <= lk_hit_f;
        pred_target <= lk_hit_f ? lk_tgt_f : '0;
      end
    end
  end

  // Pattern table and global history train on every resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) cnt[i] <= 2'b01;
      ghr <= '0;
    end else if (upd_valid) begin
      cnt[up_idx] <= up_cnt_nxt;
      ghr         <= GHR_LEN'({ghr, upd_taken});
    end
  end

  // BTB control: valid bits and round-robin pointer (wraps naturally, depth is 2^n).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_vld <= '0;
      ptr     <= '0;
    end else if (upd_valid && upd_taken && !up_hit) begin
      btb_vld[ptr] <= 1'b1;
      ptr          <= ptr + PTR_W'(1);
    end
  end

  // BTB payload: in-place retarget on hit, fill at pointer on miss.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      if (up_hit) begin
        btb_tgt[up_way] <= upd_target;
      end else begin
        btb_tag[ptr] <= upd_pc;
        btb_tgt[ptr] <= upd_target;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb_pred.sv
// tb_gshare_btb_pred: table-driven vectors plus hand sequences, all checked
// through an expected-result queue popped when pred_valid appears.
module tb_gshare_btb_pred;
  localparam int PCSIZE      = 16;
  localparam int BHT_IDX     = 8;
  localparam int GHR_LEN     = 8;
  localparam int BTB_ENTRIES = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lookup_valid = 1'b0;
  logic [PCSIZE-1:0] lookup_pc = '0;
  logic              pred_valid, pred_taken, pred_hit;
  logic [PCSIZE-1:0] pred_target;
  logic              upd_valid = 1'b0;
  logic [PCSIZE-1:0] upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [PCSIZE-1:0] upd_target = '0;

  gshare_btb_pred #(
    .PCSIZE(PCSIZE), .BHT_IDX(BHT_IDX), .GHR_LEN(GHR_LEN), .BTB_ENTRIES(BTB_ENTRIES)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              taken;
    logic              hit;
    logic [PCSIZE-1:0] tgt;
  } exp_t;

  typedef struct {
    logic              lv;
    logic [PCSIZE-1:0] lpc;
    logic              uv;
    logic [PCSIZE-1:0] upc;
    logic              ut;
    logic [PCSIZE-1:0] utgt;
    exp_t              e;
  } vec_t;

  exp_t sb[$];
  exp_t last;
  vec_t tab[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state
  logic [1:0]        m_cnt [1 << BHT_IDX];
  logic [GHR_LEN-1:0] m_ghr;
  logic              m_vld [BTB_ENTRIES];
  logic [PCSIZE-1:0] m_tag [BTB_ENTRIES];
  logic [PCSIZE-1:0] m_tgt [BTB_ENTRIES];
  int                m_ptr;

  function automatic vec_t mk(input logic lv, input logic [15:0] lpc, input logic uv,
                              input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                              input logic et, input logic eh, input logic [15:0] etg);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.e.taken = et; v.e.hit = eh; v.e.tgt = etg;
    return v;
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic int m_idx(input logic [PCSIZE-1:0] pc);
    return int'(pc[BHT_IDX+1:2] ^ m_ghr);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < (1 << BHT_IDX); i++) m_cnt[i] = 2'b01;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_ghr = '0;
    m_ptr = 0;
  endtask

  task automatic m_lookup(input logic [PCSIZE-1:0] pc, output logic [1:0] c,
                          output logic h, output logic [PCSIZE-1:0] t);
    c = m_cnt[m_idx(pc)];
    h = 1'b0;
    t = '0;
    for (int i = 0; i < BTB_ENTRIES; i++)
      if (m_vld[i] && m_tag[i] == pc) begin h = 1'b1; t = m_tgt[i]; end
  endtask

  task automatic m_update(input logic [PCSIZE-1:0] pc, input logic tk, input logic [PCSIZE-1:0] tg);
    int  ix;
    logic found;
    ix = m_idx(pc);
    m_cnt[ix] = sat(m_cnt[ix], tk);
    found = 1'b0;
    if (tk) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        if (m_vld[i] && m_tag[i] == pc) begin m_tgt[i] = tg; found = 1'b1; end
      if (!found) begin
        m_vld[m_ptr] = 1'b1; m_tag[m_ptr] = pc; m_tgt[m_ptr] = tg;
        m_ptr = (m_ptr + 1) % BTB_ENTRIES;
      end
    end
    m_ghr = {m_ghr[GHR_LEN-2:0], tk};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare whatever the previous edge produced.
  task automatic check_out();
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, sb.size() != 0});
    if (pred_valid && sb.size() != 0) last = sb.pop_front();
    else if (sb.size() != 0) void'(sb.pop_front());
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, last.taken});
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, last.hit});
    chk("pred_target", {16'd0, pred_target}, {16'd0, last.tgt});
  endtask

  task automatic cycle(input logic lv, input logic [15:0] lpc, input logic uv,
                       input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                       input logic use_tab, input exp_t texp);
    logic [1:0]        c;
    logic              h;
    logic [PCSIZE-1:0] t;
    exp_t              e;
    @(negedge clk);
    check_out();
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    if (lv) begin
      m_lookup(lpc, c, h, t);
`ifdef GSHARE_BYPASS_EN
      if (uv && m_idx(upc) == m_idx(lpc)) c = sat(m_cnt[m_idx(upc)], ut);
      if (uv && ut && upc == lpc) begin h = 1'b1; t = utgt; end
`endif
      e.taken = h && (c >= 2'd2);
      e.hit   = h;
      e.tgt   = h ? t : '0;
      sb.push_back(use_tab ? texp : e);
    end
    if (uv) m_update(upc, ut, utgt);
  endtask

  task automatic look(input logic [15:0] pc);
    cycle(1'b1, pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, '0);
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
    cycle(1'b0, 16'h0, 1'b1, pc, tk, tg, 1'b0, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #1;
    check_out();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_target", {16'd0, pred_target}, 32'd0);
    lookup_valid = 1'b0; upd_valid = 1'b0;
    sb.delete();
    last = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vectors assume the state right after reset.
    tab.push_back(mk(1, 16'h0040, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0000));
    for (int i = 0; i < 8; i++)  // drive GHR to all ones
      tab.push_back(mk(0, 16'h0, 1, 16'h1000, 1, 16'h2000, 0, 0, 16'h0));
    tab.push_back(mk(0, 16'h0, 1, 16'h0040, 1, 16'h0100, 0, 0, 16'h0));
    tab.push_back(mk(0, 16'h0, 1, 16'h0040, 1, 16'h0100, 0, 0, 16'h0));
    tab.push_back(mk(1, 16'h0040, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0100));
    tab.push_back(mk(0, 16'h0, 1, 16'h0040, 1, 16'h0100, 0, 0, 16'h0));  // taken at 3
    tab.push_back(mk(1, 16'h0040, 0, 16'h0, 0, 16'h0, 1, 1, 16'h0100));
    for (int i = 0; i < 8; i++)  // drive GHR back to zero
      tab.push_back(mk(0, 16'h0, 1, 16'h000C, 0, 16'h0, 0, 0, 16'h0));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0, 16'h0, 1, 16'h0040, 0, 16'h0, 0, 0, 16'h0));
    tab.push_back(mk(1, 16'h0040, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0100));
    for (int i = 0; i < 2; i++)  // not-taken at 0
      tab.push_back(mk(0, 16'h0, 1, 16'h0040, 0, 16'h0, 0, 0, 16'h0));
    tab.push_back(mk(1, 16'h0040, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0100));
`ifdef GSHARE_BYPASS_EN
    tab.push_back(mk(1, 16'h0080, 1, 16'h0080, 1, 16'h0200, 1, 1, 16'h0200));
`else
    tab.push_back(mk(1, 16'h0080, 1, 16'h0080, 1, 16'h0200, 0, 0, 16'h0000));
`endif
    tab.push_back(mk(1, 16'h0080, 0, 16'h0, 0, 16'h0, 0, 1, 16'h0200));
    tab.push_back(mk(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0));

    last = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset_taken", {31'd0, pred_taken}, 32'd0);
    chk("reset_hit", {31'd0, pred_hit}, 32'd0);
    chk("reset_target", {16'd0, pred_target}, 32'd0);
    rst = 1'b0;

    foreach (tab[i])
      cycle(tab[i].lv, tab[i].lpc, tab[i].uv, tab[i].upc, tab[i].ut, tab[i].utgt, 1'b1, tab[i].e);

    // Fill the BTB one past its depth; first allocation is evicted.
    async_reset();
    for (int k = 0; k <= BTB_ENTRIES; k++) upd(16'h0400 + 16'(k * 4), 1'b1, 16'h4000 + 16'(k * 4));
    for (int k = 0; k <= BTB_ENTRIES; k++) look(16'h0400 + 16'(k * 4));
    upd(16'h0500, 1'b1, 16'h5000);  // pointer sits at 1, so this evicts 0x0404
    look(16'h0404);
    look(16'h0408);
    look(16'h0500);

    // Ten updates, then reset in the middle of a cycle.
    for (int k = 0; k < 10; k++) upd(16'h0600 + 16'(k * 4), 1'b1, 16'h6000 + 16'(k * 4));
    look(16'h0408);
    async_reset();
    look(16'h0408);
    look(16'h0600);
    look(16'h0624);
    upd(16'h0408, 1'b1, 16'h7000);
    look(16'h0408);
    upd(16'h0408, 1'b1, 16'h7000);
    look(16'h0408);

    // Random traffic over a pool larger than the BTB.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] lpc, upc;
      lpc = 16'h0100 + 16'($urandom_range(0, 23) * 4);
      upc = 16'h0100 + 16'($urandom_range(0, 23) * 4);
      if ($urandom_range(0, 7) == 0) lpc = upc;
      cycle(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
            1'($urandom_range(0, 2) != 0), 16'($urandom) & 16'hFFFC, 1'b0, '0);
    end

    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, '0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_btb_pred.md
GSHARE_BTB_PRED -- requirements
Module: gshare_btb_pred

Interface
REQ-001 SHALL have parameter PCSIZE, default 16, PC/target width in bits.
REQ-002 SHALL have parameter BHT_IDX, default 8, log2 of pattern-table entries; legal range 2..PCSIZE-2.
REQ-003 SHALL have parameter GHR_LEN, default 8, global-history bits; legal range 1..BHT_IDX.
REQ-004 SHALL have parameter BTB_ENTRIES, default 16, fully-associative BTB depth; power of 2, legal range 2..64.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port lookup_valid  in  1  request a prediction for lookup_pc this cycle.
REQ-008 SHALL have port lookup_pc  in  PCSIZE  fetch PC; bits [1:0] ignored.
REQ-009 SHALL have port pred_valid  out  1  prediction outputs valid.
REQ-010 SHALL have port pred_taken  out  1  predict taken (counter >= 2 AND BTB hit).
REQ-011 SHALL have port pred_hit  out  1  lookup_pc found in BTB.
REQ-012 SHALL have port pred_target  out  PCSIZE  BTB target; 0 when pred_hit = 0.
REQ-013 SHALL have port upd_valid  in  1  resolved branch present.
REQ-014 SHALL have port upd_pc  in  PCSIZE  PC of resolved branch.
REQ-015 SHALL have port upd_taken  in  1  resolved outcome.
REQ-016 SHALL have port upd_target  in  PCSIZE  resolved target address.

Function
REQ-017 SHALL hold 2^BHT_IDX 2-bit saturating counters and a GHR_LEN-bit global history register (GHR).
REQ-018 SHALL compute index = pc[BHT_IDX+1:2] XOR zero-extended GHR, identically for lookup and update.
REQ-019 SHALL register the lookup result: pred_* valid exactly 1 cycle after the edge sampling lookup_valid = 1; pred_valid = 0 in cycles following lookup_valid = 0, with other pred_* held.
REQ-020 SHALL match BTB entries on valid bit AND full PCSIZE-bit tag equality; at most one entry matches at any time.
REQ-021 SHALL, on upd_valid, increment the indexed counter if upd_taken, saturating at 3; otherwise decrement, saturating at 0.
REQ-022 SHALL, on upd_valid, shift upd_taken into GHR bit 0 and discard the MSB; GHR SHALL never change without upd_valid.
REQ-023 SHALL, on upd_valid with upd_taken = 1 and BTB hit, overwrite that entry's target in place with no pointer change.
REQ-024 SHALL, on upd_valid with upd_taken = 1 and BTB miss, write {valid, upd_pc, upd_target} at the round-robin pointer, then advance the pointer modulo BTB_ENTRIES (wraps BTB_ENTRIES-1 -> 0, evicting the oldest allocation).
REQ-025 SHALL NOT allocate or modify BTB entries on not-taken updates.
REQ-026 SHALL, for same-cycle lookup and update, use pre-update counter, GHR and BTB state unless GSHARE_BYPASS_EN is defined.

Reset
REQ-027 SHALL, while rst = 1, force all counters to 2'b01, GHR to 0, all BTB valid bits to 0, pointer to 0, and pred_valid/pred_taken/pred_hit/pred_target to 0.
REQ-028 SHALL abandon any in-flight lookup on reset assertion; first valid prediction occurs 1 cycle after the first post-reset lookup_valid.

Configuration
REQ-029 SHALL, with GSHARE_BYPASS_EN defined, forward a same-cycle update to the lookup when the indices are equal (post-update counter used) and/or the PCs are equal with upd_taken = 1 (hit with upd_target), computing the lookup index from the pre-update GHR.
REQ-030 SHALL, without GSHARE_BYPASS_EN, make no forwarding path and show identical results to REQ-026.

Verification
REQ-031 SHALL cover reset then lookup 0x0040 -> next cycle pred_valid = 1, pred_hit = 0, pred_taken = 0, pred_target = 0.
REQ-032 SHALL cover two taken updates at 0x0040 -> 0x0100, with GHR preset so lookup maps to the same index -> pred_hit = 1, pred_target = 0x0100, pred_taken = 1; four not-taken updates -> counter 0, pred_taken = 0, pred_hit = 1.
REQ-033 SHALL cover BTB_ENTRIES+1 taken updates at distinct PCs -> first-allocated PC misses, all others hit, pointer = 1.
REQ-034 SHALL cover same-cycle lookup and taken update of 0x0080 -> 0x0200 on an empty BTB -> pred_hit = 0 without GSHARE_BYPASS_EN, pred_hit = 1 with pred_target = 0x0200 when defined.
REQ-035 SHALL cover rst asserted asynchronously mid-cycle after 10 updates -> outputs 0 immediately, all BTB entries miss, counters back to 2'b01, GHR = 0.
REQ-036 SHALL cover updates at counter 3 taken and counter 0 not-taken -> counters remain 3 and 0 (saturation).
